// File: rtl/histogram_accumulator.sv
// Multi-bank pixel histogram: pipelined read-modify-write accumulation with same-bin forwarding,
// clear sweep and registered readout. Define HISTOGRAM_SATURATE_EN for saturating bins plus overflow flag.
module histogram_accumulator #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int PIXEL_WIDTH  = 8,
  parameter int TABLE_SIZE   = 64,
  parameter int NUM_CHANNELS = 3,
  parameter int COUNT_WIDTH  = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1),
  parameter int CH_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [TABLE_SIZE*PIXEL_WIDTH-1:0] table_in,
  input  logic                              table_valid,
  input  logic [CH_WIDTH-1:0]               table_channel,
  output logic                              table_ready,
  input  logic                              clear_start,
  output logic                              busy,
  output logic                              done,
  input  logic                              rd_en,
  input  logic [CH_WIDTH-1:0]               rd_channel,
  input  logic [PIXEL_WIDTH-1:0]            rd_addr,
  output logic [COUNT_WIDTH-1:0]            rd_data,
  output logic                              rd_valid
`ifdef HISTOGRAM_SATURATE_EN
  ,
  output logic                              overflow
`endif
);

  localparam int BIN_COUNT = 2**PIXEL_WIDTH;
  localparam int IDX_WIDTH = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(TABLE_SIZE - 1);
  localparam logic [CH_WIDTH:0]    NUM_CH   = (CH_WIDTH+1)'(NUM_CHANNELS);

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DRAIN} state_t;

  state_t                            state_q;
  logic [IDX_WIDTH-1:0]              idx_q;
  logic [PIXEL_WIDTH-1:0]            clr_q;
  logic [TABLE_SIZE*PIXEL_WIDTH-1:0] table_q;
  logic [CH_WIDTH-1:0]               ch_q;
  logic                              done_q;
  logic                              w_valid_q;
  logic [PIXEL_WIDTH-1:0]            w_addr_q;
  logic                              fwd_q;
  logic [COUNT_WIDTH-1:0]            last_q;
  logic                              rd_valid_q;
  logic [CH_WIDTH-1:0]               rd_ch_q;
  logic                              rd_seen_q;
`ifdef HISTOGRAM_SATURATE_EN
  logic                              overflow_q;
  logic                              sat_s;
`endif

  logic [PIXEL_WIDTH-1:0]            cur_pix_s;
  logic                              rd_fire_s;
  logic                              ch_ok_s;
  logic [COUNT_WIDTH-1:0]            acc_rdata_s [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0]            rdo_data_s  [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0]            acc_base_s;
  logic [COUNT_WIDTH-1:0]            rdo_sel_s;
  logic [COUNT_WIDTH-1:0]            base_s;
  logic [COUNT_WIDTH-1:0]            wr_data_d;
  logic [PIXEL_WIDTH-1:0]            wr_addr_s;
  logic [COUNT_WIDTH-1:0]            wr_wdata_s;

  function automatic logic ch_in_range(input logic [CH_WIDTH-1:0] ch);
    return ({1'b0, ch} < NUM_CH);
  endfunction

  assign cur_pix_s   = table_q[PIXEL_WIDTH*int'(idx_q) +: PIXEL_WIDTH];
  assign rd_fire_s   = rd_en && (state_q == IDLE);
  assign ch_ok_s     = ch_in_range(ch_q);
  assign table_ready = (state_q == IDLE) && !clear_start && !rst;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_seen_q ? rdo_sel_s : {COUNT_WIDTH{1'b0}};
  assign wr_addr_s   = (state_q == CLEAR) ? clr_q : w_addr_q;
  assign wr_wdata_s  = (state_q == CLEAR) ? {COUNT_WIDTH{1'b0}} : wr_data_d;
`ifdef HISTOGRAM_SATURATE_EN
  assign overflow    = overflow_q;
`endif

  // Bank select for the W-stage operand and the readout data.
  always_comb begin
    acc_base_s = {COUNT_WIDTH{1'b0}};
    rdo_sel_s  = {COUNT_WIDTH{1'b0}};
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      acc_base_s = acc_base_s | ((ch_q == CH_WIDTH'(c)) ? acc_rdata_s[c] : {COUNT_WIDTH{1'b0}});
      rdo_sel_s  = rdo_sel_s  | ((rd_ch_q == CH_WIDTH'(c)) ? rdo_data_s[c] : {COUNT_WIDTH{1'b0}});
    end
  end

  // W stage: the previous pixel's result overrides the stale RAM read when both hit the same bin.
  always_comb begin
    base_s = fwd_q ? last_q : acc_base_s;
`ifdef HISTOGRAM_SATURATE_EN
    sat_s     = &base_s;
    wr_data_d = sat_s ? base_s : base_s + COUNT_WIDTH'(1);
`else
    wr_data_d = base_s + COUNT_WIDTH'(1);
`endif
  end

  // Control FSM, pipeline registers and readout handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= {IDX_WIDTH{1'b0}};
      clr_q      <= {PIXEL_WIDTH{1'b0}};
      table_q    <= {(TABLE_SIZE*PIXEL_WIDTH){1'b0}};
      ch_q       <= {CH_WIDTH{1'b0}};
      done_q     <= 1'b0;
      w_valid_q  <= 1'b0;
      w_addr_q   <= {PIXEL_WIDTH{1'b0}};
      fwd_q      <= 1'b0;
      last_q     <= {COUNT_WIDTH{1'b0}};
      rd_valid_q <= 1'b0;
      rd_ch_q    <= {CH_WIDTH{1'b0}};
      rd_seen_q  <= 1'b0;
`ifdef HISTOGRAM_SATURATE_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= rd_fire_s;
      if (rd_fire_s) begin
        rd_ch_q   <= rd_channel;
        rd_seen_q <= 1'b1;
      end
      w_valid_q <= (state_q == ACCUM);
      w_addr_q  <= cur_pix_s;
      fwd_q     <= (state_q == ACCUM) && w_valid_q && (w_addr_q == cur_pix_s);
      if (w_valid_q) begin
        last_q <= wr_data_d;
      end
`ifdef HISTOGRAM_SATURATE_EN
      if (w_valid_q && ch_ok_s && sat_s) begin
        overflow_q <= 1'b1;
      end
`endif
      case (state_q)
        IDLE: begin
          if (clear_start) begin
            clr_q   <= {PIXEL_WIDTH{1'b0}};
            state_q <= CLEAR;
          end else if (table_valid) begin
            table_q <= table_in;
            ch_q    <= table_channel;
            idx_q   <= {IDX_WIDTH{1'b0}};
            state_q <= ACCUM;
          end
        end
        CLEAR: begin
          if (clr_q == {PIXEL_WIDTH{1'b1}}) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
`ifdef HISTOGRAM_SATURATE_EN
            overflow_q <= 1'b0;
`endif
          end else begin
            clr_q <= clr_q + PIXEL_WIDTH'(1);
          end
        end
        ACCUM: begin
          if (idx_q == LAST_IDX) begin
            idx_q   <= {IDX_WIDTH{1'b0}};
            state_q <= DRAIN;
          end else begin
            idx_q <= idx_q + IDX_WIDTH'(1);
          end
        end
        DRAIN: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_bank
    logic [COUNT_WIDTH-1:0] mem_q [BIN_COUNT];
    logic [COUNT_WIDTH-1:0] acc_q;
    logic [COUNT_WIDTH-1:0] rdo_q;
    logic                   we_s;

    assign we_s = (state_q == CLEAR) || (w_valid_q && (ch_q == CH_WIDTH'(c)));

    // One bank: single write port, synchronous accumulate read and readout read.
    always_ff @(posedge clk) begin
      if (we_s) begin
        mem_q[wr_addr_s] <= wr_wdata_s;
      end
      acc_q <= mem_q[cur_pix_s];
      if (rd_fire_s) begin
        rdo_q <= mem_q[rd_addr];
      end
    end

    assign acc_rdata_s[c] = acc_q;
    assign rdo_data_s[c]  = rdo_q;
  end

endmodule
